pulse_share_sched: RTL and testbench



---
 rtl/pulse_sched_pkg.sv | 36 +++
 rtl/rr_pick.sv | 27 ++
 rtl/pulse_share_sched.sv | 134 +++++++++++++
 tb/tb_pulse_share_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse-sharing scheduler.
//   state_t : scheduler FSM states
//   idw()   : index width, never less than one bit
//   rr_next : round-robin search over a request vector (up to MAXN sources)
package pulse_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_GUARD} state_t;

  // Widest source vector rr_next can search; callers zero-extend to this.
  localparam int MAXN = 32;
  localparam int MAXW = 5;

  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of vec at or after ptr+1 (mod n). Returns 0 when vec is
  // empty; callers qualify with |vec.
  function automatic int rr_next(input int n, input int ptr,
                                 input logic [MAXN-1:0] vec);
    int   w;
    int   idx;
    logic found;
    w     = 0;
    found = 1'b0;
    for (int k = 1; k <= MAXN; k++) begin
      idx = (ptr + k) % n;
      if (k <= n && !found && vec[idx[MAXW-1:0]]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   vec : per-source request bits
//   ptr : last granted index; search starts at ptr+1
//   win : granted index (valid when any=1)
//   any : at least one request present
module rr_pick
  import pulse_sched_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = idw(N)
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] win,
  output logic           any
);

  logic [MAXN-1:0] vec_ext;

  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec;
    win            = IDW'(rr_next(N, int'(ptr), vec_ext));
    any            = |vec;
  end

endmodule

// File: rtl/pulse_share_sched.sv
// Round-robin scheduler sharing one pulse broadener between N event sources.
// Each req cycle is counted per source; pending events are replayed one at a
// time as a single-cycle pulse_out, followed by GUARD hold-off cycles so that
// consecutive broadened pulses stay apart.
//   clock, rst_n : clock, async active-low reset
//   req          : per-source event pulses
//   en           : allows new grants (in-flight sequence always completes)
//   pulse_out    : one-cycle pulse to broadener d
//   owner_id     : source owning the current/last pulse
//   owner_vld    : owner_id valid, FIRE through last GUARD cycle
//   done         : last GUARD cycle
//   busy         : FSM not idle
//   overflow     : event dropped on a saturated counter (one cycle, delayed)
//   pending_nz   : per-source counter non-zero
module pulse_share_sched
  import pulse_sched_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CW    = 2,
  parameter  int LEN   = 4,
  parameter  int LAT   = 2,
  parameter  int GUARD = LEN + LAT,
  localparam int IDW   = idw(N),
  localparam int GW    = idw(GUARD)
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic           pulse_out,
  output logic [IDW-1:0] owner_id,
  output logic           owner_vld,
  output logic           done,
  output logic           busy,
  output logic [N-1:0]   overflow,
  output logic [N-1:0]   pending_nz
);

  // Pulses repeat every GUARD+2 cycles; that must exceed the broadened width.
  if (N < 2 || GUARD < 1 || LAT < 0 || GUARD + 2 <= LEN) begin : g_bad_cfg
    $error("pulse_share_sched: invalid parameter set");
  end

  state_t               state, state_d;
  logic [GW-1:0]        gcnt, gcnt_d;
  logic [IDW-1:0]       rr_ptr;
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0]         inc, dec, sat;
  logic [IDW-1:0]       win;
  logic                 any;
  logic                 grant;

  always_comb begin
    for (int i = 0; i < N; i++) pending_nz[i] = (cnt[i] != '0);
  end

  rr_pick #(.N(N)) u_pick (
    .vec (pending_nz),
    .ptr (rr_ptr),
    .win (win),
    .any (any)
  );

  always_comb begin
    state_d = state;
    gcnt_d  = gcnt;
    grant   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && any) begin
          grant   = 1'b1;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        state_d = S_GUARD;
        gcnt_d  = GW'(GUARD - 1);
      end
      S_GUARD: begin
        if (gcnt == '0) state_d = S_IDLE;
        else            gcnt_d  = gcnt - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A saturated counter still accepts an event when the same edge grants it,
  // since the grant frees one slot.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sat[i] = (cnt[i] == {CW{1'b1}});
      dec[i] = grant && (win == IDW'(i));
      inc[i] = req[i] && (!sat[i] || dec[i]);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt[i]      <= cnt[i] + CW'(inc[i]) - CW'(dec[i]);
        overflow[i] <= req[i] && sat[i] && !dec[i];
      end
    end
  end

  // Outputs are flopped from next-state decode so they line up with state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gcnt      <= '0;
      rr_ptr    <= IDW'(N - 1);
      owner_id  <= '0;
      pulse_out <= 1'b0;
      owner_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      gcnt      <= gcnt_d;
      pulse_out <= (state_d == S_FIRE);
      owner_vld <= (state_d != S_IDLE);
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_GUARD) && (gcnt_d == '0);
      if (grant) begin
        owner_id <= win;
        rr_ptr   <= win;
      end
    end
  end

endmodule

// File: tb/tb_pulse_share_sched.sv
module tb_pulse_share_sched;

  localparam int N = 4, CW = 2, LEN = 4, LAT = 2, GUARD = 6, IDW = 2;
  localparam int MAXC = 3;

  logic           clock = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic           en    = 1'b0;
  logic           pulse_out, owner_vld, done, busy;
  logic [IDW-1:0] owner_id;
  logic [N-1:0]   overflow, pending_nz;

  pulse_share_sched #(.N(N), .CW(CW), .LEN(LEN), .LAT(LAT), .GUARD(GUARD)) dut (
    .clock(clock), .rst_n(rst_n), .req(req), .en(en),
    .pulse_out(pulse_out), .owner_id(owner_id), .owner_vld(owner_vld),
    .done(done), .busy(busy), .overflow(overflow), .pending_nz(pending_nz)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic           pulse;
    logic [IDW-1:0] owner;
    logic           vld;
    logic           done;
    logic           busy;
    logic [N-1:0]   ovf;
    logic [N-1:0]   pnz;
  } obs_t;

  typedef struct {
    logic [N-1:0] req;
    logic         en;
    obs_t         exp;
  } vec_t;

  int checks = 0;
  int passed = 0;

  // Reference model: event counts, last grant index and the cycle of the
  // last fired pulse; all outputs follow from the distance to that cycle.
  int           m_cnt[N];
  int           m_ptr, m_owner, m_cyc, m_fire;
  logic [N-1:0] m_ovf;

  int pq_cyc[$];
  int pq_own[$];
  int ovf_cnt[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.pulse = pulse_out; o.owner = owner_id; o.vld = owner_vld;
    o.done  = done;      o.busy  = busy;     o.ovf = overflow;
    o.pnz   = pending_nz;
    return o;
  endfunction

  function automatic obs_t m_obs();
    obs_t o;
    int   ph;
    ph      = m_cyc - m_fire;
    o       = '0;
    o.pulse = (ph == 0);
    o.vld   = (ph >= 0 && ph <= GUARD);
    o.busy  = o.vld;
    o.done  = (ph == GUARD);
    o.owner = IDW'(m_owner);
    o.ovf   = m_ovf;
    for (int i = 0; i < N; i++) o.pnz[i] = (m_cnt[i] != 0);
    return o;
  endfunction

  function automatic obs_t mk(logic p, logic [IDW-1:0] own, logic v, logic d, logic [N-1:0] nz);
    obs_t o;
    o = '0;
    o.pulse = p; o.owner = own; o.vld = v; o.busy = v; o.done = d; o.pnz = nz;
    return o;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = N - 1; m_owner = 0; m_cyc = 0; m_fire = -1000; m_ovf = '0;
  endtask

  task automatic clr_log();
    pq_cyc.delete(); pq_own.delete();
    for (int i = 0; i < N; i++) ovf_cnt[i] = 0;
  endtask

  // Called at a negedge: compare this cycle, drive inputs, advance model,
  // and return at the next negedge.
  task automatic step(input logic [N-1:0] r, input logic e);
    int   ph, w, room;
    logic any, g;
    check("model", dut_obs(), m_obs());
    if (pulse_out) begin pq_cyc.push_back(m_cyc); pq_own.push_back(int'(owner_id)); end
    for (int i = 0; i < N; i++) if (overflow[i]) ovf_cnt[i]++;
    req = r; en = e;
    ph  = m_cyc - m_fire;
    any = 1'b0; w = 0;
    if (!(ph >= 0 && ph <= GUARD) && e) begin
      for (int k = 1; k <= N; k++) begin
        if (!any && m_cnt[(m_ptr + k) % N] > 0) begin any = 1'b1; w = (m_ptr + k) % N; end
      end
    end
    m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      g    = any && (w == i);
      room = MAXC - m_cnt[i] + (g ? 1 : 0);
      if (r[i]) begin
        if (room > 0) m_cnt[i]++;
        else          m_ovf[i] = 1'b1;
      end
      if (g) m_cnt[i]--;
    end
    if (any) begin m_fire = m_cyc + 1; m_ptr = w; m_owner = w; end
    m_cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; en = 1'b0;
    repeat (2) @(negedge clock);
    #1 check("reset_state", dut_obs(), '0);
    @(negedge clock);
    rst_n = 1'b1;
    m_reset();
    clr_log();
  endtask

  task automatic idle_steps(input int n, input logic e);
    for (int k = 0; k < n; k++) step('0, e);
  endtask

  vec_t tbl[10];

  initial begin
    // Single req[2]: pulse two cycles later, GUARD=6 hold-off, done on last.
    tbl[0] = '{4'b0100, 1'b1, mk(0, 0, 0, 0, 4'b0000)};
    tbl[1] = '{4'b0000, 1'b1, mk(0, 0, 0, 0, 4'b0100)};
    tbl[2] = '{4'b0000, 1'b1, mk(1, 2, 1, 0, 4'b0000)};
    for (int k = 3; k <= 7; k++) tbl[k] = '{4'b0000, 1'b1, mk(0, 2, 1, 0, 4'b0000)};
    tbl[8] = '{4'b0000, 1'b1, mk(0, 2, 1, 1, 4'b0000)};
    tbl[9] = '{4'b0000, 1'b1, mk(0, 2, 0, 0, 4'b0000)};

    @(negedge clock);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tbl%0d", k), dut_obs(), tbl[k].exp);
      step(tbl[k].req, tbl[k].en);
    end

    // Burst 1011 from reset: three pulses, 8 apart, owners 0,1,3.
    do_reset();
    step(4'b1011, 1'b1);
    idle_steps(30, 1'b1);
    check("burst_cnt", pq_cyc.size(), 3);
    if (pq_cyc.size() == 3) begin
      check("burst_own", {pq_own[0][7:0], pq_own[1][7:0], pq_own[2][7:0]}, 24'h000103);
      check("burst_gap", {pq_cyc[1] - pq_cyc[0], pq_cyc[2] - pq_cyc[1]}, {32'd8, 32'd8});
      check("burst_first", pq_cyc[0], 2);
    end

    // Saturation while disabled, then drain.
    clr_log();
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b0);
    idle_steps(4, 1'b0);
    check("ovf_cnt", ovf_cnt[1], 2);
    check("held_pulses", pq_cyc.size(), 0);
    clr_log();
    idle_steps(40, 1'b1);
    check("drain_cnt", pq_cyc.size(), 3);
    if (pq_cyc.size() == 3) begin
      check("drain_own", {pq_own[0][7:0], pq_own[1][7:0], pq_own[2][7:0]}, 24'h010101);
      check("drain_gap", {pq_cyc[1] - pq_cyc[0], pq_cyc[2] - pq_cyc[1]}, {32'd8, 32'd8});
    end

    // Two sources hammering: grants alternate.
    clr_log();
    for (int k = 0; k < 48; k++) step(4'b0011, 1'b1);
    check("alt_min", pq_own.size() >= 5, 1);
    for (int k = 1; k < pq_own.size(); k++)
      check($sformatf("alt%0d", k), pq_own[k], 1 - pq_own[k-1]);
    idle_steps(60, 1'b1);

    // req[3] again on its own grant edge keeps one event queued.
    clr_log();
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    check("same_edge_nz", pending_nz, 4'b1000);
    idle_steps(25, 1'b1);
    check("same_edge_cnt", pq_cyc.size(), 2);
    if (pq_cyc.size() == 2) begin
      check("same_edge_gap", pq_cyc[1] - pq_cyc[0], 8);
      check("same_edge_own", {pq_own[0][7:0], pq_own[1][7:0]}, 16'h0303);
    end

    // Asynchronous reset mid-GUARD, then fresh priority from source 0.
    step(4'b0001, 1'b1);
    idle_steps(4, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_obs(), '0);
    @(negedge clock);
    rst_n = 1'b1;
    m_reset();
    clr_log();
    idle_steps(10, 1'b1);
    check("post_rst_quiet", pq_cyc.size(), 0);
    step(4'b1111, 1'b1);
    idle_steps(4, 1'b1);
    check("post_rst_first", pq_own.size() > 0 ? pq_own[0] : -1, 0);

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0);
      step(r, $urandom_range(0, 7) != 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
